// File: rtl/uart_mem_scheduler_pkg.sv
// Shared encodings and mailbox layout for the UART mailbox write scheduler.
package uart_mem_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR_TX,
    S_WR_RXD,
    S_WR_RXF
  } state_e;

  localparam logic [31:0] OFS_RXDATA = 32'd4;
  localparam logic [31:0] OFS_RXFLAG = 32'd8;
  localparam logic [31:0] OFS_TXDONE = 32'd12;

  localparam logic [31:0] DEF_UART0_BASE = 32'h0000_0100;
  localparam logic [31:0] DEF_UART1_BASE = 32'h0000_0110;

endpackage

// File: rtl/uart_mem_scheduler_rx.sv
// Per-UART received-byte queue; a push into a full queue is dropped and flagged.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign overflow = push & full;
  assign dout     = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mem_scheduler.sv
// Writes UART RX/TX-done events into mailbox words on idle data-memory cycles,
// round-robin between UART0 and UART1.
module uart_mem_scheduler
  import uart_mem_scheduler_pkg::*;
#(
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  UART0_BASE = ADDR_W'(DEF_UART0_BASE),
  parameter logic [ADDR_W-1:0]  UART1_BASE = ADDR_W'(DEF_UART1_BASE),
  parameter int unsigned        FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic              rx_valid0,
  input  logic              rx_valid1,
  input  logic [7:0]        rx_data0,
  input  logic [7:0]        rx_data1,
  input  logic              tx_busy0,
  input  logic              tx_busy1,
  input  logic              ovf_clr,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              ovf0,
  output logic              ovf1,
  output logic              pending
);

  state_e      state_q, state_d;
  logic        gsel_q, gsel_d;
  logic        rr_q, rr_d;
  logic [1:0]  tx_pend_q, tx_pend_d;
  logic [1:0]  tx_busy_q;
  logic [1:0]  ovf_q, ovf_d;
  logic [1:0]  tx_clr;
  logic [1:0]  req;
  logic        sel;
  logic        bus_free;
  logic [ADDR_W-1:0] base;

  logic [1:0]  rx_valid;
  logic [7:0]  rx_data   [2];
  logic [1:0]  fifo_pop, fifo_empty, fifo_full, fifo_ovfl;
  logic [7:0]  fifo_dout [2];
  logic        unused_full;

  assign rx_valid    = {rx_valid1, rx_valid0};
  assign rx_data[0]  = rx_data0;
  assign rx_data[1]  = rx_data1;
  assign unused_full = ^fifo_full;

  for (genvar i = 0; i < 2; i++) begin : g_rx
    uart_rx_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (rx_valid[i]),
      .din     (rx_data[i]),
      .pop     (fifo_pop[i]),
      .dout    (fifo_dout[i]),
      .empty   (fifo_empty[i]),
      .full    (fifo_full[i]),
      .overflow(fifo_ovfl[i])
    );
  end

  assign bus_free = ~(cpu_mem_read | cpu_mem_write);
  assign req      = tx_pend_q | ~fifo_empty;
  assign base     = gsel_q ? UART1_BASE : UART0_BASE;

  // A new falling edge is applied after the clear so a same-cycle edge is kept.
  assign tx_pend_d = (tx_pend_q & ~tx_clr) | (tx_busy_q & ~{tx_busy1, tx_busy0});
  assign ovf_d     = fifo_ovfl | (ovf_q & ~{2{ovf_clr}});

  always_comb begin
    state_d   = state_q;
    gsel_d    = gsel_q;
    rr_d      = rr_q;
    tx_clr    = '0;
    fifo_pop  = '0;
    sel       = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          sel     = (req[0] & req[1]) ? rr_q : req[1];
          gsel_d  = sel;
          state_d = tx_pend_q[sel] ? S_WR_TX : S_WR_RXD;
        end
      end
      S_WR_TX: begin
        mem_addr  = base + ADDR_W'(OFS_TXDONE);
        mem_wdata = 32'h1;
        if (bus_free) begin
          tx_clr[gsel_q] = 1'b1;
          rr_d           = ~gsel_q;
          state_d        = S_IDLE;
        end
      end
      S_WR_RXD: begin
        mem_addr  = base + ADDR_W'(OFS_RXDATA);
        mem_wdata = {24'b0, fifo_dout[gsel_q]};
        if (bus_free) state_d = S_WR_RXF;
      end
      S_WR_RXF: begin
        // Head stays queued until its flag is written, so pending covers the pair.
        mem_addr  = base + ADDR_W'(OFS_RXFLAG);
        mem_wdata = 32'h1;
        if (bus_free) begin
          fifo_pop[gsel_q] = 1'b1;
          rr_d             = ~gsel_q;
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gsel_q    <= 1'b0;
      rr_q      <= 1'b0;
      tx_pend_q <= '0;
      tx_busy_q <= '0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      gsel_q    <= gsel_d;
      rr_q      <= rr_d;
      tx_pend_q <= tx_pend_d;
      tx_busy_q <= {tx_busy1, tx_busy0};
      ovf_q     <= ovf_d;
    end
  end

  assign mem_write = (state_q != S_IDLE) & bus_free;
  assign ovf0      = ovf_q[0];
  assign ovf1      = ovf_q[1];
  assign pending   = (|tx_pend_q) | ~(&fifo_empty) | (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_mem_scheduler.sv
// Self-checking bench: transaction-level reference model of mailbox writes.
module tb_uart_mem_scheduler;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] B0 = 32'h0000_0100;
  localparam logic [31:0] B1 = 32'h0000_0110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_mem_read = 1'b0, cpu_mem_write = 1'b0;
  logic        rx_valid0 = 1'b0, rx_valid1 = 1'b0;
  logic [7:0]  rx_data0 = '0, rx_data1 = '0;
  logic        tx_busy0 = 1'b0, tx_busy1 = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        ovf0, ovf1, pending;

  always #5 clk = ~clk;

  uart_mem_scheduler #(
    .ADDR_W    (32),
    .UART0_BASE(B0),
    .UART1_BASE(B1),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_mem_read (cpu_mem_read),
    .cpu_mem_write(cpu_mem_write),
    .rx_valid0    (rx_valid0),
    .rx_valid1    (rx_valid1),
    .rx_data0     (rx_data0),
    .rx_data1     (rx_data1),
    .tx_busy0     (tx_busy0),
    .tx_busy1     (tx_busy1),
    .ovf_clr      (ovf_clr),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .ovf0         (ovf0),
    .ovf1         (ovf1),
    .pending      (pending)
  );

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  // Reference model: byte queues, pending TX-done bits, and the list of
  // writes still owed for the transaction currently being served.
  logic [7:0]  mq0[$], mq1[$];
  bit          mpend[2], movf[2], mprev[2];
  bit          mrr, act_rx, act_g;
  logic [31:0] act_addr[$], act_data[$];

  function automatic logic [31:0] ubase(bit g);
    return g ? B1 : B0;
  endfunction

  task automatic model_reset();
    mq0.delete(); mq1.delete();
    act_addr.delete(); act_data.delete();
    mpend = '{0, 0}; movf = '{0, 0}; mprev = '{0, 0};
    mrr = 0; act_rx = 0; act_g = 0;
  endtask

  function automatic logic [67:0] exp_vec();
    logic        we;
    logic [31:0] a, d;
    logic        p;
    we = (act_addr.size() != 0) && !(cpu_mem_read || cpu_mem_write);
    a  = (act_addr.size() != 0) ? act_addr[0] : 32'h0;
    d  = (act_data.size() != 0) ? act_data[0] : 32'h0;
    p  = mpend[0] || mpend[1] || mq0.size() != 0 || mq1.size() != 0 || act_addr.size() != 0;
    return {we, a, d, logic'(movf[0]), logic'(movf[1]), p};
  endfunction

  function automatic logic [67:0] obs_vec();
    return {mem_write, mem_addr, mem_wdata, ovf0, ovf1, pending};
  endfunction

  task automatic model_step();
    bit bf, full0, full1, o0, o1, r0, r1, g;
    if (!rst_n) begin
      model_reset();
      return;
    end
    bf    = !(cpu_mem_read || cpu_mem_write);
    full0 = (mq0.size() == DEPTH);
    full1 = (mq1.size() == DEPTH);
    if (act_addr.size() != 0) begin
      if (bf) begin
        void'(act_addr.pop_front());
        void'(act_data.pop_front());
        if (act_addr.size() == 0) begin
          if (act_rx) begin
            if (act_g) void'(mq1.pop_front());
            else       void'(mq0.pop_front());
          end else begin
            mpend[act_g] = 0;
          end
          mrr = !act_g;
        end
      end
    end else begin
      r0 = mpend[0] || mq0.size() != 0;
      r1 = mpend[1] || mq1.size() != 0;
      if (r0 || r1) begin
        g = (r0 && r1) ? mrr : r1;
        act_g = g;
        if (mpend[g]) begin
          act_rx = 0;
          act_addr.push_back(ubase(g) + 32'd12); act_data.push_back(32'h1);
        end else begin
          act_rx = 1;
          act_addr.push_back(ubase(g) + 32'd4);
          act_data.push_back({24'b0, g ? mq1[0] : mq0[0]});
          act_addr.push_back(ubase(g) + 32'd8); act_data.push_back(32'h1);
        end
      end
    end
    o0 = rx_valid0 && full0;
    o1 = rx_valid1 && full1;
    if (rx_valid0 && !full0) mq0.push_back(rx_data0);
    if (rx_valid1 && !full1) mq1.push_back(rx_data1);
    movf[0] = o0 ? 1'b1 : (ovf_clr ? 1'b0 : movf[0]);
    movf[1] = o1 ? 1'b1 : (ovf_clr ? 1'b0 : movf[1]);
    if (mprev[0] && !tx_busy0) mpend[0] = 1;
    if (mprev[1] && !tx_busy1) mpend[1] = 1;
    mprev[0] = tx_busy0;
    mprev[1] = tx_busy1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (obs_vec() !== 68'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", obs_vec());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL reset_idle c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_rx_single();
    logic [31:0] wa[$], wd[$];
    int first = -1;
    rx_valid0 = 1'b1; rx_data0 = 8'hA5;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rx_single c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (mem_write) begin
        if (first < 0) first = c;
        wa.push_back(mem_addr); wd.push_back(mem_wdata);
      end
      tick();
      rx_valid0 = 1'b0;
    end
    n_cmp++;
    if (wa.size() != 2 || wa[0] !== 32'h104 || wd[0] !== 32'hA5 || wa[1] !== 32'h108 || wd[1] !== 32'h1 || first != 2) begin
      n_fail++;
      $display("FAIL rx_single_seq: got n=%0d first=%0d %h<-%h %h<-%h want n=2 first=2 104<-a5 108<-1",
               wa.size(), first, wa[0], wd[0], wa[1], wd[1]);
    end
    n_cmp++;
    if (pending !== 1'b0) begin
      n_fail++; $display("FAIL rx_single_pending: got %b want 0", pending);
    end
  endtask

  task automatic test_tx_stall();
    logic [31:0] wa[$], wd[$];
    int first = -1;
    tx_busy1 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL tx_busy c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    tx_busy1 = 1'b0; cpu_mem_write = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL tx_stall c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (mem_write) begin
        if (first < 0) first = c;
        wa.push_back(mem_addr); wd.push_back(mem_wdata);
      end
      tick();
      if (c == 4) cpu_mem_write = 1'b0;
    end
    n_cmp++;
    if (wa.size() != 1 || wa[0] !== 32'h11C || wd[0] !== 32'h1 || first != 5) begin
      n_fail++;
      $display("FAIL tx_stall_seq: got n=%0d first=%0d %h<-%h want n=1 first=5 11c<-1", wa.size(), first, wa[0], wd[0]);
    end
  endtask

  task automatic test_rr();
    logic [31:0] wa[$];
    logic [31:0] exp_a[4];
    for (int phase = 0; phase < 3; phase++) begin
      wa.delete();
      rx_valid0 = 1'b1; rx_data0 = 8'h10 + 8'(phase);
      rx_valid1 = (phase != 1); rx_data1 = 8'h20 + 8'(phase);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL rr p%0d c%0d: got %h want %h", phase, c, obs_vec(), exp_vec());
        end
        if (mem_write) wa.push_back(mem_addr);
        tick();
        rx_valid0 = 1'b0; rx_valid1 = 1'b0;
      end
      if (phase != 1) begin
        if (phase == 0) exp_a = '{32'h104, 32'h108, 32'h114, 32'h118};
        else            exp_a = '{32'h114, 32'h118, 32'h104, 32'h108};
        n_cmp++;
        if (wa.size() != 4 || wa[0] !== exp_a[0] || wa[1] !== exp_a[1] || wa[2] !== exp_a[2] || wa[3] !== exp_a[3]) begin
          n_fail++;
          $display("FAIL rr_order p%0d: got n=%0d %h %h %h %h want %h %h %h %h", phase, wa.size(),
                   wa[0], wa[1], wa[2], wa[3], exp_a[0], exp_a[1], exp_a[2], exp_a[3]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] wd[$];
    cpu_mem_write = 1'b1;
    for (int c = 0; c < 6; c++) begin
      rx_valid0 = (c < 5); rx_data0 = 8'(c + 1);
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL ovf_fill c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    rx_valid0 = 1'b0;
    n_cmp++;
    if (ovf0 !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got %b want 1", ovf0);
    end
    cpu_mem_write = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL ovf_drain c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (mem_write && mem_addr == 32'h104) wd.push_back(mem_wdata);
      tick();
    end
    n_cmp++;
    if (wd.size() != 4 || wd[0] !== 32'd1 || wd[1] !== 32'd2 || wd[2] !== 32'd3 || wd[3] !== 32'd4) begin
      n_fail++;
      $display("FAIL ovf_order: got n=%0d %h %h %h %h want 1 2 3 4", wd.size(), wd[0], wd[1], wd[2], wd[3]);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ovf0 !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clr: got %b want 0", ovf0);
    end
    tick();
  endtask

  task automatic test_stall_between();
    int after = -1;
    logic [31:0] after_a = '0;
    for (int c = 0; c < 14; c++) begin
      rx_valid0    = (c == 0); rx_data0 = 8'h3C;
      rx_valid1    = (c == 3); rx_data1 = 8'h5A;
      cpu_mem_read = (c >= 3 && c <= 5);
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stall_mid c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 4) begin
        n_cmp++;
        if (mem_write !== 1'b0 || mem_addr !== 32'h108 || mem_wdata !== 32'h1) begin
          n_fail++; $display("FAIL stall_hold: got we=%b %h<-%h want we=0 108<-1", mem_write, mem_addr, mem_wdata);
        end
      end
      if (c > 3 && mem_write && after < 0) begin
        after = c; after_a = mem_addr;
      end
      tick();
    end
    rx_valid0 = 1'b0; rx_valid1 = 1'b0; cpu_mem_read = 1'b0;
    n_cmp++;
    if (after != 6 || after_a !== 32'h108) begin
      n_fail++; $display("FAIL stall_resume: got c%0d %h want c6 108", after, after_a);
    end
  endtask

  task automatic test_random();
    int guard;
    for (int c = 0; c < 400; c++) begin
      cpu_mem_read  = ($urandom % 4) == 0;
      cpu_mem_write = ($urandom % 5) == 0;
      rx_valid0     = ($urandom % 3) == 0;
      rx_valid1     = ($urandom % 4) == 0;
      rx_data0      = 8'($urandom);
      rx_data1      = 8'($urandom);
      if (($urandom % 6) == 0) tx_busy0 = ~tx_busy0;
      if (($urandom % 7) == 0) tx_busy1 = ~tx_busy1;
      ovf_clr       = ($urandom % 20) == 0;
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    {cpu_mem_read, cpu_mem_write, rx_valid0, rx_valid1, tx_busy0, tx_busy1, ovf_clr} = '0;
    guard = 0;
    while (guard < 60 && !(guard > 2 && exp_vec() == 68'h0 && !movf[0] && !movf[1])) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_drain g%0d: got %h want %h", guard, obs_vec(), exp_vec());
      end
      tick();
      ovf_clr = 1'b1;
      guard++;
    end
    ovf_clr = 1'b0;
    n_cmp++;
    if (guard >= 60 || pending !== 1'b0) begin
      n_fail++; $display("FAIL random_drain_timeout: got pending=%b after %0d cycles want 0", pending, guard);
    end
  endtask

  task automatic test_reset_mid();
    cpu_mem_write = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rx_valid0 = (c < 2); rx_data0 = 8'h70 + 8'(c);
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rst_fill c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    rx_valid0 = 1'b0; cpu_mem_write = 1'b0;
    #1;
    n_cmp++;
    if (mem_write !== 1'b1 || mem_addr !== 32'h104 || mem_wdata !== 32'h70) begin
      n_fail++; $display("FAIL rst_pre: got we=%b %h<-%h want we=1 104<-70", mem_write, mem_addr, mem_wdata);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (obs_vec() !== 68'h0) begin
      n_fail++; $display("FAIL rst_async: got %h want 0", obs_vec());
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_write !== 1'b0 || pending !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rst_after c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rx_single();
    test_tx_stall();
    test_rr();
    test_overflow();
    test_stall_between();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
